// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state type and one-hot helper for onehot_decoder_seq.
// Used by both the DECODE_SCAN_EN build and the direct-only build.
package decoder_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    // Widest one-hot vector; callers truncate to their own width.
    function automatic logic [MAX_OUT_W-1:0] onehot(
        input logic [MAX_SEL_W-1:0] sel
    );
        onehot = MAX_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_dwell_timer.sv
// dwell_timer: loadable down-counter that sets the scan dwell per position.
// Counts down to zero and stops there until it is reloaded.
module dwell_timer
    import decoder_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] count;

    // Load takes priority over the decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered SEL_W -> 2^SEL_W one-hot decoder with handshake.
// Define DECODE_SCAN_EN to add the scan mode (walking bit with programmable dwell).
module onehot_decoder_seq
    import decoder_pkg::*;
#(
    parameter  int SEL_W   = 2,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic               scan_wrap
);

    state_t           state;
    state_t           state_nx;
    logic [OUT_W-1:0] out_nx;
    logic [OUT_W-1:0] cap;
    logic [OUT_W-1:0] cap_nx;
    logic             valid_nx;
    logic [OUT_W-1:0] sel_oh;
    logic             xfer;

    assign sel_oh = OUT_W'(onehot(MAX_SEL_W'(sel_in)));
    assign xfer   = in_valid & in_ready;

`ifdef DECODE_SCAN_EN
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] idx_nx;
    logic [SEL_W-1:0] idx_inc;
    logic [OUT_W-1:0] idx_oh;
    logic [OUT_W-1:0] inc_oh;
    logic             wrap_nx;
    logic             load;
    logic             dec;
    logic             zero;

    assign idx_inc  = idx + SEL_W'(1);
    assign idx_oh   = OUT_W'(onehot(MAX_SEL_W'(idx)));
    assign inc_oh   = OUT_W'(onehot(MAX_SEL_W'(idx_inc)));
    assign in_ready = ~rst & en & ~mode & (state != SCAN);
`else
    logic unused_scan;

    assign unused_scan = ^{mode, dwell};
    assign in_ready    = ~rst & en;
`endif

    // Next state, next output and captured value; en low blanks and freezes.
    always_comb begin
        state_nx = state;
        out_nx   = out;
        cap_nx   = cap;
        valid_nx = out_valid;
`ifdef DECODE_SCAN_EN
        idx_nx   = idx;
        wrap_nx  = 1'b0;
        load     = 1'b0;
        dec      = 1'b0;
`endif
        if (!en) begin
            out_nx   = '0;
            valid_nx = 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
`ifdef DECODE_SCAN_EN
                    if (mode) begin
                        state_nx = SCAN;
                        idx_nx   = '0;
                        out_nx   = OUT_W'(1);
                        valid_nx = 1'b1;
                        load     = 1'b1;
                    end else
`endif
                    if (xfer) begin
                        state_nx = HOLD;
                        out_nx   = sel_oh;
                        cap_nx   = sel_oh;
                        valid_nx = 1'b1;
                    end else if (state == HOLD) begin
                        out_nx   = cap;
                        valid_nx = 1'b1;
                    end else begin
                        out_nx   = '0;
                        valid_nx = 1'b0;
                    end
                end
`ifdef DECODE_SCAN_EN
                SCAN: begin
                    valid_nx = 1'b1;
                    if (!mode) begin
                        state_nx = HOLD;
                        out_nx   = idx_oh;
                        cap_nx   = idx_oh;
                    end else if (zero) begin
                        load    = 1'b1;
                        idx_nx  = idx_inc;
                        out_nx  = inc_oh;
                        wrap_nx = &idx;
                    end else begin
                        dec    = 1'b1;
                        out_nx = idx_oh;
                    end
                end
`endif
                default: begin
                    state_nx = IDLE;
                    out_nx   = '0;
                    valid_nx = 1'b0;
                end
            endcase
        end
    end

    // Registered state and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            cap       <= '0;
        end else begin
            state     <= state_nx;
            out       <= out_nx;
            out_valid <= valid_nx;
            cap       <= cap_nx;
        end
    end

`ifdef DECODE_SCAN_EN
    // Scan position and wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            scan_wrap <= 1'b0;
        end else begin
            idx       <= idx_nx;
            scan_wrap <= wrap_nx;
        end
    end

    dwell_timer #(
        .DWELL_W(DWELL_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .dec     (dec),
        .load_val(dwell),
        .zero    (zero)
    );
`else
    assign scan_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: directed and random checks of two decoder widths.
// Scan scenarios are exercised when DECODE_SCAN_EN is defined.
`timescale 1ns/1ps
module tb_onehot_decoder_seq;

`ifdef DECODE_SCAN_EN
    localparam bit SCAN_BUILD = 1'b1;
`else
    localparam bit SCAN_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] sel2 = '0;
    logic [2:0] sel3 = '0;
    logic [7:0] dwell = '0;

    logic       rdy2, v2, w2;
    logic [3:0] out2;
    logic       rdy3, v3, w3;
    logic [7:0] out3;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: one entry per instance (0 = SEL_W 2, 1 = SEL_W 3).
    bit         m_scan [2];
    bit         m_have [2];
    int         pos    [2];
    int         age    [2];
    int         ow     [2];
    logic [7:0] m_val  [2];
    logic [7:0] e_out  [2];
    bit         e_v    [2];
    bit         e_w    [2];

    onehot_decoder_seq #(.SEL_W(2), .DWELL_W(8)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy2), .sel_in(sel2),
        .dwell(dwell), .out(out2), .out_valid(v2), .scan_wrap(w2)
    );

    onehot_decoder_seq #(.SEL_W(3), .DWELL_W(8)) dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy3), .sel_in(sel3),
        .dwell(dwell), .out(out3), .out_valid(v3), .scan_wrap(w3)
    );

    always #5 clk = ~clk;

    function automatic bit exp_rdy(int i);
        return !rst && en && !(SCAN_BUILD && mode) && !m_scan[i];
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic step();
        int sel;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = (i == 0) ? int'(sel2) : int'(sel3);
            e_w[i] = 1'b0;
            if (rst) begin
                m_scan[i] = 0; m_have[i] = 0; m_val[i] = '0;
                pos[i] = 0; age[i] = 0; e_out[i] = '0; e_v[i] = 0;
            end else if (!en) begin
                e_out[i] = '0; e_v[i] = 0;
            end else if (m_scan[i]) begin
                if (!mode) begin
                    m_scan[i] = 0; m_have[i] = 1;
                    m_val[i] = 8'(1 << pos[i]);
                end else if (age[i] == int'(dwell)) begin
                    age[i] = 0;
                    pos[i] = (pos[i] + 1) % ow[i];
                    e_w[i] = (pos[i] == 0);
                end else begin
                    age[i]++;
                end
                e_out[i] = 8'(1 << pos[i]); e_v[i] = 1;
            end else if (SCAN_BUILD && mode) begin
                m_scan[i] = 1; pos[i] = 0; age[i] = 0;
                e_out[i] = 8'd1; e_v[i] = 1;
            end else begin
                if (in_valid) begin
                    m_have[i] = 1; m_val[i] = 8'(1 << sel);
                end
                e_out[i] = m_have[i] ? m_val[i] : 8'd0;
                e_v[i] = m_have[i];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b1;
        #1;
        n_checks++;
        if (rdy2 !== 1'b0 || rdy3 !== 1'b0)
            $display("FAIL reset_ready got %b%b exp 00", rdy2, rdy3);
        else n_pass++;
        step(); step();
        n_checks++;
        if (out2 !== 4'b0 || v2 !== 1'b0 || w2 !== 1'b0)
            $display("FAIL reset_out2 got %b v%b w%b exp 0000 v0 w0", out2, v2, w2);
        else n_pass++;
        n_checks++;
        if (out3 !== 8'b0 || v3 !== 1'b0 || w3 !== 1'b0)
            $display("FAIL reset_out3 got %b v%b w%b exp 0 v0 w0", out3, v3, w3);
        else n_pass++;
        rst = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_direct();
        logic [3:0] exp;
        en = 1'b1; mode = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel2 = 2'(k); sel3 = 3'($urandom);
            exp = 4'(1 << k);
            #1;
            n_checks++;
            if (rdy2 !== 1'b1) $display("FAIL direct_ready sel %0d got %b exp 1", k, rdy2);
            else n_pass++;
            step();
            n_checks++;
            if (out2 !== exp || v2 !== 1'b1)
                $display("FAIL direct_out2 sel %0d got %b v%b exp %b v1", k, out2, v2, exp);
            else n_pass++;
            n_checks++;
            if (out3 !== e_out[1] || v3 !== e_v[1])
                $display("FAIL direct_out3 sel %0d got %b exp %b", sel3, out3, e_out[1]);
            else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_hold_en();
        sel2 = 2'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (out2 !== 4'b0100 || v2 !== 1'b1)
                $display("FAIL hold_out cyc %0d got %b v%b exp 0100 v1", c, out2, v2);
            else n_pass++;
        end
        en = 1'b0;
        #1;
        n_checks++;
        if (rdy2 !== 1'b0) $display("FAIL en_low_ready got %b exp 0", rdy2);
        else n_pass++;
        step();
        n_checks++;
        if (out2 !== 4'b0 || v2 !== 1'b0)
            $display("FAIL en_low_out got %b v%b exp 0000 v0", out2, v2);
        else n_pass++;
        en = 1'b1;
        step();
        n_checks++;
        if (out2 !== 4'b0100 || v2 !== 1'b1)
            $display("FAIL en_restore got %b v%b exp 0100 v1", out2, v2);
        else n_pass++;
    endtask

`ifdef DECODE_SCAN_EN
    task automatic test_scan();
        logic [3:0] exp;
        dwell = 8'd2; mode = 1'b1;
        step();
        n_checks++;
        if (out2 !== 4'b0001 || v2 !== 1'b1 || w2 !== 1'b0)
            $display("FAIL scan_entry got %b v%b w%b exp 0001 v1 w0", out2, v2, w2);
        else n_pass++;
        for (int t = 1; t <= 18; t++) begin
            step();
            exp = 4'(1 << ((t / 3) % 4));
            n_checks++;
            if (out2 !== exp || w2 !== (t == 12) || rdy2 !== 1'b0)
                $display("FAIL scan_walk t %0d got %b w%b r%b exp %b w%b r0",
                         t, out2, w2, rdy2, exp, (t == 12));
            else n_pass++;
        end
        mode = 1'b0;
        step();
        n_checks++;
        if (out2 !== 4'b0100 || v2 !== 1'b1 || w2 !== 1'b0 || rdy2 !== 1'b1)
            $display("FAIL scan_exit got %b v%b w%b r%b exp 0100 v1 w0 r1",
                     out2, v2, w2, rdy2);
        else n_pass++;
        sel2 = 2'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out2 !== 4'b0001 || v2 !== 1'b1)
            $display("FAIL scan_exit_xfer got %b v%b exp 0001 v1", out2, v2);
        else n_pass++;
    endtask

    task automatic test_scan_reset();
        dwell = 8'd2; mode = 1'b1;
        step();
        repeat (9) step();
        n_checks++;
        if (out2 !== 4'b1000) $display("FAIL scan_pre_reset got %b exp 1000", out2);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rdy2 !== 1'b0) $display("FAIL rst_ready got %b exp 0", rdy2);
        else n_pass++;
        step();
        n_checks++;
        if (out2 !== 4'b0 || v2 !== 1'b0 || w2 !== 1'b0 || rdy2 !== 1'b0)
            $display("FAIL scan_reset got %b v%b w%b r%b exp 0000 v0 w0 r0",
                     out2, v2, w2, rdy2);
        else n_pass++;
        rst = 1'b0; mode = 1'b0;
        step();
    endtask

    task automatic test_sel3_walk();
        logic [7:0] exp;
        dwell = 8'd0; mode = 1'b1;
        step();
        n_checks++;
        if (out3 !== 8'd1 || w3 !== 1'b0)
            $display("FAIL walk_entry got %b w%b exp 00000001 w0", out3, w3);
        else n_pass++;
        for (int t = 1; t <= 16; t++) begin
            step();
            exp = 8'(1 << (t % 8));
            n_checks++;
            if (out3 !== exp || w3 !== ((t % 8) == 0))
                $display("FAIL walk t %0d got %b w%b exp %b w%b",
                         t, out3, w3, exp, ((t % 8) == 0));
            else n_pass++;
        end
        mode = 1'b0;
        step();
    endtask
`else
    task automatic test_mode_ignored();
        logic [7:0] exp;
        mode = 1'b1; dwell = 8'd0; en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = 1'b1;
            sel2 = 2'($urandom); sel3 = 3'($urandom);
            exp = 8'(1 << sel3);
            #1;
            n_checks++;
            if (rdy3 !== 1'b1) $display("FAIL noscan_ready got %b exp 1", rdy3);
            else n_pass++;
            step();
            n_checks++;
            if (out3 !== exp || v3 !== 1'b1 || w3 !== 1'b0 || w2 !== 1'b0)
                $display("FAIL noscan_out got %b v%b w%b%b exp %b v1 w00",
                         out3, v3, w3, w2, exp);
            else n_pass++;
        end
        in_valid = 1'b0; mode = 1'b0;
    endtask
`endif

    task automatic test_random();
        dwell = 8'($urandom_range(0, 3));
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            in_valid = 1'($urandom_range(0, 1));
            sel2 = 2'($urandom); sel3 = 3'($urandom);
            #1;
            n_checks++;
            if (rdy2 !== exp_rdy(0) || rdy3 !== exp_rdy(1))
                $display("FAIL rand_ready cyc %0d got %b%b exp %b%b",
                         c, rdy2, rdy3, exp_rdy(0), exp_rdy(1));
            else n_pass++;
            step();
            n_checks++;
            if ({4'b0, out2} !== e_out[0] || v2 !== e_v[0] || w2 !== e_w[0])
                $display("FAIL rand_out2 cyc %0d got %b v%b w%b exp %b v%b w%b",
                         c, out2, v2, w2, e_out[0][3:0], e_v[0], e_w[0]);
            else n_pass++;
            n_checks++;
            if (out3 !== e_out[1] || v3 !== e_v[1] || w3 !== e_w[1])
                $display("FAIL rand_out3 cyc %0d got %b v%b w%b exp %b v%b w%b",
                         c, out3, v3, w3, e_out[1], e_v[1], e_w[1]);
            else n_pass++;
        end
        rst = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0;
        step();
    endtask

    initial begin
        ow[0] = 4;
        ow[1] = 8;
        test_reset();
        test_direct();
        test_hold_en();
`ifdef DECODE_SCAN_EN
        test_scan();
        test_scan_reset();
        test_sel3_walk();
`else
        test_mode_ignored();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Registered, parametrised successor to the team's 2-to-4 decoder: converts a SEL_W-bit select into a 2^SEL_W one-hot output. Adds an enable, a valid/ready capture handshake, and a scan mode in which an internal counter walks the one-hot bit across all outputs with a programmable dwell. Sits between control logic and one-hot consumers such as row/bank selects and LED/mux strobes.

## Interface
- SEL_W, 2, select width; output width OUT_W = 2^SEL_W (legal 1..6)
- DWELL_W, 8, width of the dwell-count input
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  block enable; 0 freezes state and blanks output
- mode  input  1  0 = direct decode, 1 = scan
- in_valid  input  1  sel_in is valid
- in_ready  output  1  block accepts sel_in this cycle
- sel_in  input  SEL_W  binary select
- dwell  input  DWELL_W  scan: cycles per position = dwell + 1
- out  output  OUT_W  registered one-hot (or all-zero) output
- out_valid  output  1  out holds a decoded value
- scan_wrap  output  1  one-cycle pulse when scan index wraps to 0

Clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.

## Operation
- States: IDLE, HOLD, SCAN.
- Reset: state IDLE, out = 0, out_valid = 0, scan_wrap = 0, scan index = 0, dwell counter = 0.
- in_ready = en & ~mode & (state != SCAN), combinational; it is 0 while rst is high.
- IDLE/HOLD, mode = 0: a transfer (in_valid & in_ready) loads out = 1 << sel_in and sets out_valid = 1. State goes to HOLD. Without a transfer, out holds its value.
- IDLE/HOLD, mode = 1, en = 1: go to SCAN. Index = 0, out = 1, out_valid = 1, dwell counter loaded with dwell.
- SCAN: the dwell counter decrements each cycle. At 0 it reloads from dwell (sampled at reload) and the index advances.
  - index OUT_W-1 -> 0 wraps, and scan_wrap = 1 on the cycle out returns to bit 0.
  - dwell = 0 advances every cycle.
- SCAN, mode -> 0: on the next cycle state goes to HOLD. out keeps its current one-hot value. No scan_wrap is generated.
- en = 0 (any state): out = 0 and out_valid = 0 on the next cycle. State, index and counter are frozen. When en returns to 1, out is restored to 1 << index (SCAN) or the last captured value (HOLD). IDLE stays blank.
- A transfer and a mode 0 -> 1 change in the same cycle are not possible, because in_ready requires mode = 0.
- rst asserted mid-scan or mid-transfer: reset wins, and all reset values apply on the next edge.

## Timing
- Direct decode latency: 1 cycle from the transfer edge to out/out_valid.
- Scan entry: out = 1 one cycle after mode is sampled high.
- Each scan position lasts exactly dwell + 1 cycles. A full period is OUT_W × (dwell + 1) cycles.
- scan_wrap is high for exactly 1 cycle, aligned with out = 1 after a wrap. It is never asserted on the initial scan entry.
- All outputs except in_ready are registered.

## Configuration
- DECODE_SCAN_EN defined: full behaviour as above.
- DECODE_SCAN_EN undefined:
  - SCAN state, dwell counter and index logic are removed.
  - mode and dwell are ignored.
  - scan_wrap is tied to 0.
  - in_ready = en.
  - The block is a registered direct decoder with handshake only.

## Structure
- Package decoder_pkg holds:
  - the state enum (IDLE, HOLD, SCAN)
  - the function onehot(sel) returning the OUT_W vector
  - the constant MAX_SEL_W = 6
- One sub-module, dwell_timer:
  - DWELL_W-bit down-counter with load and a zero flag
  - instantiated only under DECODE_SCAN_EN

## Test plan
- Reset, then SEL_W=2, mode=0, transfers of sel_in 0,1,2,3 -> out 0001, 0010, 0100, 1000, each 1 cycle after its transfer, with out_valid=1.
- Hold in_valid=0 for 10 cycles after sel_in=2 -> out stays 0100. Then en=0 -> out=0000, out_valid=0 next cycle. Then en=1 -> 0100 restored.
- mode=1, dwell=2 -> each bit lasts 3 cycles. Sequence 0001, 0010, 0100, 1000, 0001. scan_wrap pulses once, 12 cycles after entry, aligned with the return to 0001.
- Mid-scan at out=0100, mode -> 0 -> HOLD with out=0100 and in_ready=1. Then a transfer with sel_in=0 -> out=0001.
- rst asserted while scanning at out=1000 -> next cycle out=0, out_valid=0, scan_wrap=0, in_ready=0 while rst is high.
- SEL_W=3, dwell=0, scan -> out walks through all 8 bits on consecutive cycles and scan_wrap pulses every 8 cycles. Repeat with DECODE_SCAN_EN undefined -> mode is ignored and scan_wrap stays 0.
